// File: rtl/dual_write_pkg.sv
// Shared defaults and priority encodings for the dual write-port scheduler.
package dual_write_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_CNT_W  = 8;

  localparam logic PRIO_REQ1 = 1'b0;
  localparam logic PRIO_REQ2 = 1'b1;

endpackage

// File: rtl/write_slot.sv
// One-entry holding register for a single write requester; cleared by a grant unless refilled.
module write_slot #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              grant_i,
  output logic              ready_o,
  output logic              pend_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [WIDTH-1:0]  data_o
);

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              accept;

  // Granted entry leaves this edge, so the slot may refill back-to-back.
  assign ready_o = ~pend_q | grant_i;
  assign accept  = valid_i & ready_o;

  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    data_d = data_q;
    if (accept) begin
      pend_d = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end else if (grant_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign pend_o = pend_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/dual_write_port_scheduler.sv
// Two requesters share the two storage write ports; same-address pairs are serialised round-robin.
module dual_write_port_scheduler
  import dual_write_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_data,
  output logic              req1_ready,
  input  logic              req2_valid,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [WIDTH-1:0]  req2_data,
  output logic              req2_ready,
  input  logic              hold,
  output logic              wr_en_1,
  output logic [ADDR_W-1:0] wr_addr_1,
  output logic [WIDTH-1:0]  wr_data_1,
  output logic              wr_en_2,
  output logic [ADDR_W-1:0] wr_addr_2,
  output logic [WIDTH-1:0]  wr_data_2,
  output logic [CNT_W-1:0]  collision_cnt,
  output logic              rr_prio
);

  logic              pend1, pend2;
  logic [ADDR_W-1:0] addr1, addr2;
  logic [WIDTH-1:0]  data1, data2;
  logic              grant1, grant2;
  logic              same_addr, collision;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  write_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_slot1 (
    .clk_i   (clk),
    .rst_ni  (reset),
    .valid_i (req1_valid),
    .addr_i  (req1_addr),
    .data_i  (req1_data),
    .grant_i (grant1),
    .ready_o (req1_ready),
    .pend_o  (pend1),
    .addr_o  (addr1),
    .data_o  (data1)
  );

  write_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_slot2 (
    .clk_i   (clk),
    .rst_ni  (reset),
    .valid_i (req2_valid),
    .addr_i  (req2_addr),
    .data_i  (req2_data),
    .grant_i (grant2),
    .ready_o (req2_ready),
    .pend_o  (pend2),
    .addr_o  (addr2),
    .data_o  (data2)
  );

  assign same_addr = pend1 & pend2 & (addr1 == addr2);
  assign collision = same_addr & ~hold;

  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (!hold) begin
      if (same_addr) begin
        grant1 = (rr_q == PRIO_REQ1);
        grant2 = (rr_q == PRIO_REQ2);
      end else begin
        grant1 = pend1;
        grant2 = pend2;
      end
    end
  end

  always_comb begin
    rr_d  = rr_q;
    cnt_d = cnt_q;
    if (collision) begin
      rr_d = ~rr_q;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q  <= PRIO_REQ1;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  assign wr_en_1       = grant1;
  assign wr_addr_1     = addr1;
  assign wr_data_1     = data1;
  assign wr_en_2       = grant2;
  assign wr_addr_2     = addr2;
  assign wr_data_2     = data2;
  assign collision_cnt = cnt_q;
  assign rr_prio       = rr_q;

endmodule

// File: tb/tb_dual_write_port_scheduler.sv
// Table vectors, directed corner sequences and randomized traffic against a reference model.
module tb_dual_write_port_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req1_valid, req2_valid, req1_ready, req2_ready, hold;
  logic [2:0]  req1_addr, req2_addr, wr_addr_1, wr_addr_2;
  logic [15:0] req1_data, req2_data, wr_data_1, wr_data_2;
  logic        wr_en_1, wr_en_2, rr_prio;
  logic [7:0]  collision_cnt;

  int checks = 0;
  int errors = 0;

  dual_write_port_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .req1_valid    (req1_valid),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .req2_valid    (req2_valid),
    .req2_addr     (req2_addr),
    .req2_data     (req2_data),
    .req2_ready    (req2_ready),
    .hold          (hold),
    .wr_en_1       (wr_en_1),
    .wr_addr_1     (wr_addr_1),
    .wr_data_1     (wr_data_1),
    .wr_en_2       (wr_en_2),
    .wr_addr_2     (wr_addr_2),
    .wr_data_2     (wr_data_2),
    .collision_cnt (collision_cnt),
    .rr_prio       (rr_prio)
  );

  always #5 clk = ~clk;

  // Storage as seen through the DUT write ports, and as predicted by the model.
  logic [15:0] dut_mem [8] = '{default: 16'h0};
  logic [15:0] ref_mem [8] = '{default: 16'h0};
  always @(posedge clk) begin
    if (wr_en_1) dut_mem[wr_addr_1] <= wr_data_1;
    if (wr_en_2) dut_mem[wr_addr_2] <= wr_data_2;
  end

  // Reference model: one pending write per requester plus priority and collision tally.
  logic        mp [2];
  logic [2:0]  ma [2];
  logic [15:0] md [2];
  logic        mrr;
  int          mcnt;
  logic        mg0, mg1, mr0, mr1;

  logic        track_order = 1'b0;
  int          order_q [$];
  logic        count_en = 1'b0;
  int          port1_writes = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      mp[k] = 1'b0;
      ma[k] = 3'd0;
      md[k] = 16'd0;
    end
    mrr  = 1'b0;
    mcnt = 0;
  endfunction

  task automatic drive_check(input logic v1, input logic [2:0] a1, input logic [15:0] d1,
                             input logic v2, input logic [2:0] a2, input logic [15:0] d2,
                             input logic h);
    logic clash;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    req2_valid = v2; req2_addr = a2; req2_data = d2;
    hold = h;
    #4;
    clash = mp[0] && mp[1] && (ma[0] == ma[1]);
    mg0 = !h && mp[0] && (!clash || mrr == 1'b0);
    mg1 = !h && mp[1] && (!clash || mrr == 1'b1);
    mr0 = !mp[0] || mg0;
    mr1 = !mp[1] || mg1;
    chk("wr_en_1", 32'(wr_en_1), 32'(mg0));
    chk("wr_en_2", 32'(wr_en_2), 32'(mg1));
    if (mg0) begin
      chk("wr_addr_1", 32'(wr_addr_1), 32'(ma[0]));
      chk("wr_data_1", 32'(wr_data_1), 32'(md[0]));
    end
    if (mg1) begin
      chk("wr_addr_2", 32'(wr_addr_2), 32'(ma[1]));
      chk("wr_data_2", 32'(wr_data_2), 32'(md[1]));
    end
    chk("req1_ready", 32'(req1_ready), 32'(mr0));
    chk("req2_ready", 32'(req2_ready), 32'(mr1));
    chk("collision_cnt", 32'(collision_cnt), 32'(mcnt));
    chk("rr_prio", 32'(rr_prio), 32'(mrr));
    if (track_order) begin
      if (wr_en_1 && !wr_en_2) order_q.push_back(1);
      if (wr_en_2 && !wr_en_1) order_q.push_back(2);
    end
    if (count_en && wr_en_1) port1_writes++;
  endtask

  task automatic step();
    logic clash;
    @(posedge clk);
    clash = mp[0] && mp[1] && (ma[0] == ma[1]) && !hold;
    if (clash) begin
      mrr  = !mrr;
      mcnt = (mcnt < 255) ? mcnt + 1 : 255;
    end
    if (mg0) ref_mem[ma[0]] = md[0];
    if (mg1) ref_mem[ma[1]] = md[1];
    if (req1_valid && mr0) begin mp[0] = 1'b1; ma[0] = req1_addr; md[0] = req1_data; end
    else if (mg0) mp[0] = 1'b0;
    if (req2_valid && mr1) begin mp[1] = 1'b1; ma[1] = req2_addr; md[1] = req2_data; end
    else if (mg1) mp[1] = 1'b0;
    #1;
  endtask

  task automatic cycle(input logic v1, input logic [2:0] a1, input logic [15:0] d1,
                       input logic v2, input logic [2:0] a2, input logic [15:0] d2,
                       input logic h);
    drive_check(v1, a1, d1, v2, a2, d2, h);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
  endtask

  // Reset asserted mid-cycle; outputs must reach reset values without a clock edge.
  task automatic do_reset();
    req1_valid = 1'b0; req2_valid = 1'b0; hold = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst wr_en_1", 32'(wr_en_1), 32'd0);
    chk("rst wr_en_2", 32'(wr_en_2), 32'd0);
    chk("rst req1_ready", 32'(req1_ready), 32'd1);
    chk("rst req2_ready", 32'(req2_ready), 32'd1);
    chk("rst collision_cnt", 32'(collision_cnt), 32'd0);
    chk("rst rr_prio", 32'(rr_prio), 32'd0);
    model_clear();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    logic v1; logic [2:0] a1; logic [15:0] d1;
    logic v2; logic [2:0] a2; logic [15:0] d2;
    logic h;
    logic e1; logic e2; logic [15:0] ed1; logic [15:0] ed2;
    logic r1; logic r2; logic [7:0] cnt; logic rr;
  } vec_t;

  vec_t tbl [6];
  int   exp_order [8];

  initial begin
    logic        rv1, rv2;
    logic [2:0]  ra1, ra2;
    logic [15:0] rd1, rd2;

    // Expectations sampled before the edge that applies the row's inputs.
    tbl[0] = '{1, 3'd1, 16'd25, 1, 3'd2, 16'd50,  0, 0, 0, 16'd0,  16'd0,   1, 1, 8'd0, 0};
    tbl[1] = '{0, 3'd0, 16'd0,  0, 3'd0, 16'd0,   0, 1, 1, 16'd25, 16'd50,  1, 1, 8'd0, 0};
    tbl[2] = '{1, 3'd3, 16'd75, 1, 3'd3, 16'd100, 0, 0, 0, 16'd0,  16'd0,   1, 1, 8'd0, 0};
    tbl[3] = '{0, 3'd0, 16'd0,  0, 3'd0, 16'd0,   0, 1, 0, 16'd75, 16'd0,   1, 0, 8'd0, 0};
    tbl[4] = '{0, 3'd0, 16'd0,  0, 3'd0, 16'd0,   0, 0, 1, 16'd0,  16'd100, 1, 1, 8'd1, 1};
    tbl[5] = '{0, 3'd0, 16'd0,  0, 3'd0, 16'd0,   0, 0, 0, 16'd0,  16'd0,   1, 1, 8'd1, 1};
    exp_order = '{1, 2, 2, 1, 1, 2, 2, 1};

    model_clear();
    reset = 1'b0;
    req1_valid = 1'b0; req2_valid = 1'b0; hold = 1'b0;
    req1_addr = 3'd0; req2_addr = 3'd0; req1_data = 16'd0; req2_data = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // T2/T3 disjoint and colliding pairs
    foreach (tbl[i]) begin
      drive_check(tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].v2, tbl[i].a2, tbl[i].d2, tbl[i].h);
      chk($sformatf("tbl%0d wr_en_1", i), 32'(wr_en_1), 32'(tbl[i].e1));
      chk($sformatf("tbl%0d wr_en_2", i), 32'(wr_en_2), 32'(tbl[i].e2));
      if (tbl[i].e1) chk($sformatf("tbl%0d wr_data_1", i), 32'(wr_data_1), 32'(tbl[i].ed1));
      if (tbl[i].e2) chk($sformatf("tbl%0d wr_data_2", i), 32'(wr_data_2), 32'(tbl[i].ed2));
      chk($sformatf("tbl%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].r1));
      chk($sformatf("tbl%0d req2_ready", i), 32'(req2_ready), 32'(tbl[i].r2));
      chk($sformatf("tbl%0d cnt", i), 32'(collision_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d rr", i), 32'(rr_prio), 32'(tbl[i].rr));
      step();
    end

    // T1 reset with both slots pending under hold
    cycle(1'b1, 3'd6, 16'h11, 1'b1, 3'd7, 16'h22, 1'b1);
    drive_check(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
    chk("pre-rst req1_ready", 32'(req1_ready), 32'd0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_check(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
      chk("post-rst no wr_en", 32'(wr_en_1 | wr_en_2), 32'd0);
      step();
    end

    // T4 fairness: four back-to-back collisions
    track_order = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'd3, 16'(2 * i), 1'b1, 3'd3, 16'(2 * i + 1), 1'b0);
      idle(3);
    end
    track_order = 1'b0;
    chk("order size", 32'(order_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < order_q.size(); i++)
      chk($sformatf("order[%0d]", i), 32'(order_q[i]), 32'(exp_order[i]));
    chk("fair cnt", 32'(collision_cnt), 32'd4);

    // T5 hold with both slots full
    cycle(1'b1, 3'd4, 16'd111, 1'b1, 3'd5, 16'd222, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_check(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
      chk("hold no wr_en", 32'(wr_en_1 | wr_en_2), 32'd0);
      chk("hold ready", 32'(req1_ready | req2_ready), 32'd0);
      step();
    end
    drive_check(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    chk("hold rel en", 32'({wr_en_1, wr_en_2}), 32'd3);
    chk("hold rel d1", 32'(wr_data_1), 32'd111);
    chk("hold rel d2", 32'(wr_data_2), 32'd222);
    step();

    // T6 streaming and counter saturation
    count_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_check(1'b1, 3'(i % 8), 16'(i), 1'b0, 3'd0, 16'd0, 1'b0);
      chk("stream ready", 32'(req1_ready), 32'd1);
      step();
    end
    idle(2);
    count_en = 1'b0;
    chk("stream writes", 32'(port1_writes), 32'd100);

    do_reset();
    for (int i = 0; i < 262; i++) cycle(1'b1, 3'd5, 16'(i), 1'b1, 3'd5, 16'(i + 1000), 1'b0);
    chk("sat cnt", 32'(collision_cnt), 32'd255);
    idle(3);

    // Randomized traffic; requests stay stable while stalled.
    do_reset();
    rv1 = 1'b0; rv2 = 1'b0; ra1 = 3'd0; ra2 = 3'd0; rd1 = 16'd0; rd2 = 16'd0;
    for (int i = 0; i < 1500; i++) begin
      if (!(rv1 && !mr0)) begin
        rv1 = ($urandom_range(0, 3) != 0); ra1 = 3'($urandom_range(0, 3)); rd1 = 16'($urandom);
      end
      if (!(rv2 && !mr1)) begin
        rv2 = ($urandom_range(0, 3) != 0); ra2 = 3'($urandom_range(0, 3)); rd2 = 16'($urandom);
      end
      cycle(rv1, ra1, rd1, rv2, ra2, rd2, ($urandom_range(0, 4) == 0));
    end
    idle(4);
    for (int k = 0; k < 8; k++) chk($sformatf("mem[%0d]", k), 32'(dut_mem[k]), 32'(ref_mem[k]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
